// File: rtl/core_pkg.sv
// core_pkg: shared types and constants for the RV32 multi-cycle core.
package core_pkg;
    localparam int XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic {FETCH, EXEC} fetch_state_t;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: selects the next PC from jump/branch controls and flags unaligned targets.
module pc_next_mux
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            b_out,
    input  logic            jal,
    input  logic            jalr,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);
    always_comb begin
        next_pc    = jalr ? {alu_result[XLEN-1:1], 1'b0} : (jal || b_out) ? pc + imm : pc + XLEN'(4);
        misaligned = |next_pc[1:0];
    end
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and req/ack instruction fetch FSM; one instruction per FETCH+EXEC pair.
module pc_fetch_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            if_req,
    output logic [XLEN-1:0] if_addr,
    input  logic            if_ack,
    input  logic [31:0]     if_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    input  logic            ex_stall,
    input  logic            b_out,
    input  logic            jal,
    input  logic            jalr,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            misalign_err,
    output logic [31:0]     instret
);
    fetch_state_t state, state_d;
    logic [XLEN-1:0] next_pc;
    logic misaligned, fetch_done, retire;

    pc_next_mux #(.XLEN(XLEN)) u_next (
        .pc(pc), .imm(imm), .alu_result(alu_result),
        .b_out(b_out), .jal(jal), .jalr(jalr),
        .next_pc(next_pc), .misaligned(misaligned)
    );

    always_ff @(posedge clk)
        state <= rst ? FETCH : state_d;

    always_comb begin
        fetch_done = (state == FETCH) && if_ack;
        retire     = (state == EXEC) && !ex_stall;
        state_d    = fetch_done ? EXEC : retire ? FETCH : state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc           <= XLEN'(RESET_PC);
            instr        <= NOP_INSTR;
            instr_valid  <= 1'b0;
            misalign_err <= 1'b0;
            instret      <= '0;
        end else if (fetch_done) begin
            instr       <= if_rdata;
            instr_valid <= 1'b1;
        end else if (retire) begin
            pc           <= next_pc;
            instr_valid  <= 1'b0;
            instret      <= instret + 32'd1;
            misalign_err <= misalign_err | misaligned;
        end
    end

    assign if_req   = (state == FETCH);
    assign if_addr  = pc;
    assign pc_plus4 = pc + XLEN'(4);
endmodule
